// File: rtl/ps2_host_tx_if.sv
// Requester-side handshake for the PS/2 host transmitter: command byte in,
// ready/busy status and one-cycle done/err completion pulses out.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       done;
  logic       err;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  busy,
    input  done,
    input  err
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output busy,
    output done,
    output err
  );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, requests to send, then
// shifts a command byte out on device-generated clock falls and checks the ACK.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 2500,
  parameter int unsigned TIMEOUT_CYCLES = 375000,
  parameter int unsigned CNT_W          = 19
) (
  input  logic         clk,
  input  logic         rst,
  ps2_host_tx_if.slave req,
  input  logic         k_clk_in,
  input  logic         k_data_in,
  output logic         k_clk_oe,
  output logic         k_data_oe
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_INHIBIT  = 3'd1;
  localparam logic [2:0] S_RTS      = 3'd2;
  localparam logic [2:0] S_WAIT_DEV = 3'd3;
  localparam logic [2:0] S_SHIFT    = 3'd4;
  localparam logic [2:0] S_ACK      = 3'd5;
  localparam logic [2:0] S_WAIT_REL = 3'd6;

  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [9:0]       r_shift;
  logic [3:0]       r_bitcnt;
  logic             r_clk_oe;
  logic             r_data_oe;
  logic             r_done;
  logic             r_err;
  logic             r_kclk_s1;
  logic             r_kclk_s2;
  logic             r_kclk_prev;
  logic             r_kdata_s1;
  logic             r_kdata_s2;

  logic             w_fall;
  logic             w_timeout;

  assign w_fall    = r_kclk_prev & ~r_kclk_s2;
  assign w_timeout = (r_cnt == TO_LAST);

  assign req.tx_ready = (r_state == S_IDLE);
  assign req.busy     = (r_state != S_IDLE);
  assign req.done     = r_done;
  assign req.err      = r_err;
  assign k_clk_oe     = r_clk_oe;
  assign k_data_oe    = r_data_oe;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_shift     <= '1;
      r_bitcnt    <= '0;
      r_clk_oe    <= 1'b0;
      r_data_oe   <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_kclk_s1   <= 1'b1;
      r_kclk_s2   <= 1'b1;
      r_kclk_prev <= 1'b1;
      r_kdata_s1  <= 1'b1;
      r_kdata_s2  <= 1'b1;
    end else begin
      r_kclk_s1   <= k_clk_in;
      r_kclk_s2   <= r_kclk_s1;
      r_kclk_prev <= r_kclk_s2;
      r_kdata_s1  <= k_data_in;
      r_kdata_s2  <= r_kdata_s1;
      r_done      <= 1'b0;
      r_err       <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (req.tx_valid) begin
            r_shift   <= {1'b1, ~^req.tx_data, req.tx_data};
            r_cnt     <= '0;
            r_clk_oe  <= 1'b1;
            r_data_oe <= 1'b0;
            r_state   <= S_INHIBIT;
          end
        end

        S_INHIBIT: begin
          if (r_cnt == INH_LAST) begin
            r_data_oe <= 1'b1;
            r_state   <= S_RTS;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_RTS: begin
          r_clk_oe <= 1'b0;
          r_cnt    <= '0;
          r_state  <= S_WAIT_DEV;
        end

        // The first fall already drives data bit 0, so it is shifted here.
        S_WAIT_DEV: begin
          if (w_fall) begin
            r_cnt     <= '0;
            r_data_oe <= ~r_shift[0];
            r_shift   <= {1'b1, r_shift[9:1]};
            r_bitcnt  <= '0;
            r_state   <= S_SHIFT;
          end else if (w_timeout) begin
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
            r_err     <= 1'b1;
            r_state   <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_SHIFT: begin
          if (w_fall) begin
            r_cnt     <= '0;
            r_data_oe <= ~r_shift[0];
            r_shift   <= {1'b1, r_shift[9:1]};
            r_bitcnt  <= r_bitcnt + 1'b1;
            if (r_bitcnt == 4'd8) begin
              r_state <= S_ACK;
            end
          end else if (w_timeout) begin
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
            r_err     <= 1'b1;
            r_state   <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_ACK: begin
          if (w_fall) begin
            r_cnt <= '0;
            if (!r_kdata_s2) begin
              r_state <= S_WAIT_REL;
            end else begin
              r_clk_oe  <= 1'b0;
              r_data_oe <= 1'b0;
              r_err     <= 1'b1;
              r_state   <= S_IDLE;
            end
          end else if (w_timeout) begin
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
            r_err     <= 1'b1;
            r_state   <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_WAIT_REL: begin
          if (r_kclk_s2 && r_kdata_s2) begin
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end else if (w_fall) begin
            r_cnt <= '0;
          end else if (w_timeout) begin
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
            r_err     <= 1'b1;
            r_state   <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        default: begin
          r_clk_oe  <= 1'b0;
          r_data_oe <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule
